// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - serial-bitstream decoder for the 6-symbol Huffman code
module huffman_decoder #(
  parameter int NUM_SYM = 100,
  parameter int MAX_LEN = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   code_valid,
  input  logic [6*MAX_LEN-1:0]   HC,
  input  logic [6*MAX_LEN-1:0]   M,
  output logic                   table_err,
  input  logic                   bit_valid,
  input  logic                   bit_data,
  output logic                   bit_ready,
  output logic                   sym_valid,
  output logic [7:0]             sym_data,
  output logic                   dec_err,
  output logic                   done
);

  typedef enum logic {IDLE, DECODE} state_t;

  state_t state, state_n;

  logic [MAX_LEN-1:0] tbl_hc [6];
  logic [MAX_LEN-1:0] tbl_m  [6];

  logic [MAX_LEN-1:0] acc, acc_nx, acc_d;
  logic [3:0]         len, len_nx, len_d;
  logic [7:0]         sym_cnt, cnt_inc, cnt_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               masks_ok;
  logic               load;
  logic               match_found;
  logic [7:0]         match_sym;
  logic               sv_d, de_d, dn_d, te_d;
  logic [7:0]         sd_d;

  // A usable mask is non-zero with all ones packed at the bottom (2^L-1).
  function automatic logic mask_ok(input logic [MAX_LEN-1:0] m);
    return (m != '0) &&
           ((m & (m + {{(MAX_LEN-1){1'b0}}, 1'b1})) == '0);
  endfunction

  assign bit_ready = (state == DECODE);
  assign acc_nx    = {acc[MAX_LEN-2:0], bit_data};
  assign len_nx    = len + 4'd1;
  assign cnt_inc   = sym_cnt + 8'd1;

  // Validate all six incoming masks in one go.
  always_comb begin
    masks_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!mask_ok(M[(6-i)*MAX_LEN-1 -: MAX_LEN])) masks_ok = 1'b0;
    end
  end

  // Mask a codeword of the post-shift length would carry, and the table lookup;
  // scanning downwards lets the lowest symbol index win on overlap.
  always_comb begin
    len_mask    = '0;
    match_found = 1'b0;
    match_sym   = 8'd0;
    for (int k = 0; k < MAX_LEN; k++) begin
      len_mask[k] = (4'(k) < len_nx);
    end
    for (int i = 5; i >= 0; i--) begin
      if ((tbl_m[i] == len_mask) && ((tbl_hc[i] & tbl_m[i]) == acc_nx)) begin
        match_found = 1'b1;
        match_sym   = 8'(i + 1);
      end
    end
  end

  // Next-state and next-output decision.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    acc_d   = acc;
    len_d   = len;
    cnt_d   = sym_cnt;
    sv_d    = 1'b0;
    sd_d    = 8'd0;
    de_d    = 1'b0;
    dn_d    = 1'b0;
    te_d    = 1'b0;
    case (state)
      IDLE: begin
        if (code_valid) begin
          if (masks_ok) begin
            load    = 1'b1;
            acc_d   = '0;
            len_d   = 4'd0;
            cnt_d   = 8'd0;
            state_n = DECODE;
          end else begin
            te_d = 1'b1;
          end
        end
      end
      DECODE: begin
        if (bit_valid) begin
          if (match_found) begin
            sv_d  = 1'b1;
            sd_d  = match_sym;
            acc_d = '0;
            len_d = 4'd0;
            cnt_d = cnt_inc;
            if (cnt_inc == 8'(NUM_SYM)) begin
              dn_d    = 1'b1;
              state_n = IDLE;
            end
          end else if (len_nx == 4'(MAX_LEN)) begin
            de_d  = 1'b1;
            acc_d = '0;
            len_d = 4'd0;
          end else begin
            acc_d = acc_nx;
            len_d = len_nx;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Code table, replaced only by an accepted load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        tbl_hc[i] <= '0;
        tbl_m[i]  <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < 6; i++) begin
        tbl_hc[i] <= HC[(6-i)*MAX_LEN-1 -: MAX_LEN];
        tbl_m[i]  <= M[(6-i)*MAX_LEN-1 -: MAX_LEN];
      end
    end
  end

  // Accumulator, length, symbol count and registered output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      len       <= 4'd0;
      sym_cnt   <= 8'd0;
      sym_valid <= 1'b0;
      sym_data  <= 8'd0;
      dec_err   <= 1'b0;
      done      <= 1'b0;
      table_err <= 1'b0;
    end else begin
      acc       <= acc_d;
      len       <= len_d;
      sym_cnt   <= cnt_d;
      sym_valid <= sv_d;
      sym_data  <= sd_d;
      dec_err   <= de_d;
      done      <= dn_d;
      table_err <= te_d;
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// tb/tb_huffman_decoder.sv - scoreboard bench for huffman_decoder
module tb_huffman_decoder;

  localparam int NSYM = 5;
  localparam int ML   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [47:0] HC;
  logic [47:0] M;
  logic        table_err;
  logic        bit_valid;
  logic        bit_data;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym_data;
  logic        dec_err;
  logic        done;

  always #5 clk = ~clk;

  huffman_decoder #(.NUM_SYM(NSYM), .MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .HC(HC), .M(M),
    .table_err(table_err), .bit_valid(bit_valid), .bit_data(bit_data),
    .bit_ready(bit_ready), .sym_valid(sym_valid), .sym_data(sym_data),
    .dec_err(dec_err), .done(done)
  );

  typedef struct {
    int stamp;
    int sv;
    int sd;
    int de;
    int dn;
    int te;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  // Reference model: a table of (code value, code length) pairs and the
  // pending bit string as an integer value plus its length.
  int mhc[6];
  int mm[6];
  bit m_dec = 1'b0;
  int pv = 0;
  int pl = 0;
  int cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
  endtask

  function automatic bit mask_valid(input int m);
    for (int l = 1; l <= ML; l++) if (m == (1 << l) - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int sv, input int sd, input int de, input int dn, input int te);
    exp_t e;
    e.stamp = cyc + 1;
    e.sv = sv; e.sd = sd; e.de = de; e.dn = dn; e.te = te;
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input bit bv, input bit bd, input bit cv,
                            input logic [47:0] hc, input logic [47:0] m);
    bit ok;
    int hit;
    if (!m_dec) begin
      if (cv) begin
        ok = 1'b1;
        for (int i = 0; i < 6; i++) if (!mask_valid(int'(m[(6-i)*8-1 -: 8]))) ok = 1'b0;
        if (ok) begin
          for (int i = 0; i < 6; i++) begin
            mhc[i] = int'(hc[(6-i)*8-1 -: 8]);
            mm[i]  = int'(m[(6-i)*8-1 -: 8]);
          end
          m_dec = 1'b1; pv = 0; pl = 0; cnt = 0;
        end else begin
          push(0, 0, 0, 0, 1);
        end
      end
    end else if (bv) begin
      pv = ((pv << 1) | int'(bd)) & 255;
      pl++;
      hit = 0;
      for (int i = 0; i < 6; i++)
        if (hit == 0 && $countones(mm[i]) == pl && (mhc[i] & mm[i]) == pv) hit = i + 1;
      if (hit != 0) begin
        cnt++;
        push(1, hit, 0, (cnt == NSYM) ? 1 : 0, 0);
        if (cnt == NSYM) m_dec = 1'b0;
        pv = 0; pl = 0;
      end else if (pl == ML) begin
        push(0, 0, 1, 0, 0);
        pv = 0; pl = 0;
      end
    end
  endtask

  task automatic step(input bit bv, input bit bd, input bit cv,
                      input logic [47:0] hc, input logic [47:0] m);
    code_valid = cv; HC = hc; M = m; bit_valid = bv; bit_data = bd;
    @(negedge clk);
    check("bit_ready", int'(bit_ready), int'(m_dec));
    model_edge(bv, bd, cv, hc, m);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 48'd0, 48'd0);
    check("queue_empty_before_reset", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_data", int'(sym_data), 0);
    check("rst_dec_err", int'(dec_err), 0);
    check("rst_done", int'(done), 0);
    check("rst_table_err", int'(table_err), 0);
    check("rst_bit_ready", int'(bit_ready), 0);
    m_dec = 1'b0; pv = 0; pl = 0; cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (sym_valid || dec_err || done || table_err) begin
      check("expected_queue_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_cycle", cyc, e.stamp);
        check("sym_valid", int'(sym_valid), e.sv);
        check("sym_data", int'(sym_data), e.sd);
        check("dec_err", int'(dec_err), e.de);
        check("done", int'(done), e.dn);
        check("table_err", int'(table_err), e.te);
      end
    end else begin
      check("sym_data_idle_zero", int'(sym_data), 0);
      if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        check("output_present", 0 + int'(sym_valid | dec_err | done | table_err), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  logic [47:0] t1_hc = 48'h00_02_06_0E_1E_1F;
  logic [47:0] t1_m  = 48'h01_03_07_0F_1F_1F;

  initial begin
    int seq1[];
    int seq2[];
    logic [47:0] rhc, rm;
    int l, steps;
    reset = 1'b0; code_valid = 1'b0; HC = '0; M = '0; bit_valid = 1'b0; bit_data = 1'b0;
    #2;
    check("init_sym_valid", int'(sym_valid), 0);
    check("init_sym_data", int'(sym_data), 0);
    check("init_dec_err", int'(dec_err), 0);
    check("init_done", int'(done), 0);
    check("init_table_err", int'(table_err), 0);
    check("init_bit_ready", int'(bit_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic table, then a two-bit codeword and a continuous multi-symbol run.
    step(1'b0, 1'b0, 1'b1, t1_hc, t1_m);
    seq1 = '{1, 0};
    foreach (seq1[k]) step(1'b1, seq1[k][0], 1'b0, 48'd0, 48'd0);
    seq2 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    foreach (seq2[k]) step(1'b1, seq2[k][0], 1'b0, 48'd0, 48'd0);

    // Reset after four symbols: table gone, bits refused.
    do_reset();
    repeat (2) step(1'b1, 1'b1, 1'b0, 48'd0, 48'd0);

    // Malformed mask for symbol 3 is rejected; a good load still works.
    step(1'b0, 1'b0, 1'b1, t1_hc, 48'h01_03_05_0F_1F_1F);
    repeat (2) step(1'b1, 1'b0, 1'b0, 48'd0, 48'd0);
    step(1'b0, 1'b0, 1'b1, t1_hc, t1_m);
    steps = 0;
    while (m_dec && steps < 200) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 48'd0, 48'd0);
      steps++;
    end
    check("first_pass_finished", int'(m_dec), 0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 48'd0, 48'd0);

    // Seven-bit codes of zeros: eight ones give a decode error, then a fresh word.
    step(1'b0, 1'b0, 1'b1, 48'd0, {6{8'h7F}});
    repeat (8) step(1'b1, 1'b1, 1'b0, 48'd0, 48'd0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 48'd0, 48'd0);
    do_reset();

    // Random tables (some malformed) with gappy random bitstreams.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 6; i++) begin
        l = $urandom_range(1, 8);
        rm[(6-i)*8-1 -: 8] = 8'((1 << l) - 1);
        rhc[(6-i)*8-1 -: 8] = 8'($urandom) & rm[(6-i)*8-1 -: 8];
      end
      if ($urandom_range(0, 4) == 0) rm[23:16] = 8'($urandom);
      step(1'b0, 1'b0, 1'b1, rhc, rm);
      steps = 0;
      while (m_dec && steps < 3000) begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 19) == 0, 48'($urandom) << 16, 48'hFF_FF_FF_FF_FF_FF);
        steps++;
      end
      if (m_dec) do_reset();
      step(1'b0, 1'b0, 1'b0, 48'd0, 48'd0);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 48'd0, 48'd0);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
